// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: op encoding,
// FSM states, access size, alignment and byte-lane helpers.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_ls_op_t;

  typedef enum logic [1:0] {
    LSU_ST_IDLE,
    LSU_ST_REQ,
    LSU_ST_WAIT
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_SZ_B,
    LSU_SZ_H,
    LSU_SZ_W
  } lsu_size_t;

  function automatic logic lsu_is_load(input lsu_ls_op_t op);
    return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
  endfunction

  function automatic lsu_size_t lsu_size(input lsu_ls_op_t op);
    lsu_size_t sz;
    unique case (op)
      LSU_LB, LSU_LBU, LSU_SB: sz = LSU_SZ_B;
      LSU_LH, LSU_LHU, LSU_SH: sz = LSU_SZ_H;
      default:                 sz = LSU_SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic lsu_aligned(input lsu_size_t sz, input logic [1:0] lo);
    logic ok;
    unique case (sz)
      LSU_SZ_B: ok = 1'b1;
      LSU_SZ_H: ok = (lo[0] == 1'b0);
      default:  ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lsu_be(input lsu_size_t sz, input logic [1:0] lo);
    logic [3:0] be;
    unique case (sz)
      LSU_SZ_B: be = 4'b0001 << lo;
      LSU_SZ_H: be = 4'b0011 << lo;
      default:  be = 4'hF;
    endcase
    return be;
  endfunction

  // Replicating the datum across lanes lets the byte enables pick the lane.
  function automatic logic [31:0] lsu_lane_wdata(input lsu_size_t sz, input logic [31:0] wd);
    logic [31:0] d;
    unique case (sz)
      LSU_SZ_B: d = {4{wd[7:0]}};
      LSU_SZ_H: d = {2{wd[15:0]}};
      default:  d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave):
// req/gnt request handshake, rvalid/err response.
interface mem_lsu_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/mem_lsu_load_align.sv
// Combinational load formatter: selects the byte/half at the access offset
// and sign- or zero-extends it according to the load op.
module mem_lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  lsu_ls_op_t  i_op,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;

  always_comb begin
    w_sh   = i_rdata >> {i_addr_lo, 3'b000};
    o_data = w_sh;
    unique case (i_op)
      LSU_LB:  o_data = {{24{w_sh[7]}}, w_sh[7:0]};
      LSU_LBU: o_data = {24'd0, w_sh[7:0]};
      LSU_LH:  o_data = {{16{w_sh[15]}}, w_sh[15:0]};
      LSU_LHU: o_data = {16'd0, w_sh[15:0]};
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: masters the data-memory bus, stalls the pipe
// while a transaction is outstanding. Optional WAIT watchdog: COTM32_LSU_TIMEOUT_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  lsu_ls_op_t  i_ls_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_t_load_addr_misaligned,
  output logic        o_t_store_addr_misaligned,
  output logic        o_t_load_access_fault,
  output logic        o_t_store_access_fault,
  mem_lsu_if.master   bus
);

  lsu_state_t  r_state, w_next;
  lsu_ls_op_t  r_op;
  logic [29:0] r_waddr;
  logic [1:0]  r_addr_lo;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_killed;

  lsu_size_t   w_size;
  logic        w_req_op, w_aligned, w_accept, w_misal;
  logic        w_timeout, w_rsp, w_err, w_keep, w_ld_op;
  logic [31:0] w_ld_data;

  assign w_size    = lsu_size(i_ls_op);
  assign w_req_op  = (r_state == LSU_ST_IDLE) & i_valid & (i_ls_op != LSU_NONE) & ~i_flush;
  assign w_aligned = lsu_aligned(w_size, i_addr[1:0]);
  assign w_accept  = w_req_op & w_aligned;
  assign w_misal   = w_req_op & ~w_aligned;

  // A real response wins over a watchdog expiry landing in the same cycle.
  assign w_rsp   = (r_state == LSU_ST_WAIT) & (bus.rvalid | w_timeout);
  assign w_err   = bus.rvalid ? bus.err : 1'b1;
  assign w_keep  = w_rsp & ~r_killed & ~i_flush;
  assign w_ld_op = lsu_is_load(r_op);

`ifdef COTM32_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == LSU_ST_WAIT) && !w_rsp) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == LSU_ST_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_timeout        = 1'b0;
`endif

  mem_lsu_load_align u_load_align (
    .i_rdata   (bus.rdata),
    .i_addr_lo (r_addr_lo),
    .i_op      (r_op),
    .o_data    (w_ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LSU_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op      <= LSU_NONE;
      r_waddr   <= '0;
      r_addr_lo <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_killed  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= i_ls_op;
        r_waddr   <= i_addr[31:2];
        r_addr_lo <= i_addr[1:0];
        r_be      <= lsu_be(w_size, i_addr[1:0]);
        r_wdata   <= lsu_lane_wdata(w_size, i_wdata);
        r_we      <= ~lsu_is_load(i_ls_op);
        r_killed  <= 1'b0;
      end else if ((r_state != LSU_ST_IDLE) && i_flush) begin
        r_killed  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next                    = r_state;
    o_stall                   = 1'b0;
    o_done                    = 1'b0;
    o_rdata                   = '0;
    o_t_load_addr_misaligned  = 1'b0;
    o_t_store_addr_misaligned = 1'b0;
    o_t_load_access_fault     = 1'b0;
    o_t_store_access_fault    = 1'b0;
    unique case (r_state)
      LSU_ST_IDLE: begin
        if (w_accept) begin
          w_next  = LSU_ST_REQ;
          o_stall = 1'b1;
        end
        if (w_misal) begin
          o_done                    = 1'b1;
          o_t_load_addr_misaligned  = lsu_is_load(i_ls_op);
          o_t_store_addr_misaligned = ~lsu_is_load(i_ls_op);
        end
      end
      LSU_ST_REQ: begin
        o_stall = 1'b1;
        if (bus.gnt) w_next = LSU_ST_WAIT;
      end
      LSU_ST_WAIT: begin
        if (w_rsp) begin
          w_next = LSU_ST_IDLE;
          if (w_keep) begin
            o_done = 1'b1;
            if (w_err) begin
              o_t_load_access_fault  = w_ld_op;
              o_t_store_access_fault = ~w_ld_op;
            end else if (w_ld_op) begin
              o_rdata = w_ld_data;
            end
          end
        end else begin
          o_stall = 1'b1;
        end
      end
      default: w_next = LSU_ST_IDLE;
    endcase
  end

  assign bus.req   = (r_state == LSU_ST_REQ);
  assign bus.addr  = {r_waddr, 2'b00};
  assign bus.we    = r_we;
  assign bus.be    = r_be;
  assign bus.wdata = r_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed ops push expected results, a
// negedge monitor pops and compares whenever o_done is seen.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  lsu_ls_op_t  i_ls_op = LSU_NONE;
  logic [31:0] i_addr  = '0;
  logic [31:0] i_wdata = '0;
  logic        o_stall, o_done;
  logic [31:0] o_rdata;
  logic        lam, sam, laf, saf;

  mem_lsu_if bus ();

  mem_lsu #(.TIMEOUT_CYCLES(255)) dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_valid                   (i_valid),
    .i_ls_op                   (i_ls_op),
    .i_addr                    (i_addr),
    .i_wdata                   (i_wdata),
    .i_flush                   (i_flush),
    .o_stall                   (o_stall),
    .o_done                    (o_done),
    .o_rdata                   (o_rdata),
    .o_t_load_addr_misaligned  (lam),
    .o_t_store_addr_misaligned (sam),
    .o_t_load_access_fault     (laf),
    .o_t_store_access_fault    (saf),
    .bus                       (bus)
  );

  always #5 clk = ~clk;

  // flags = {load_misaligned, store_misaligned, load_fault, store_fault}
  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic [3:0] fl);
    exp_t e;
    e.rdata = rd;
    e.flags = fl;
    return e;
  endfunction

  exp_t m_e;
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {31'd0, o_done}, 32'd0);
      end else begin
        m_e = sb_q.pop_front();
        chk("rdata", o_rdata, m_e.rdata);
        chk("trap_flags", {28'd0, lam, sam, laf, saf}, {28'd0, m_e.flags});
      end
    end
  end

  task automatic bus_idle();
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.err    = 1'b0;
    bus.rdata  = '0;
    i_flush    = 1'b0;
  endtask

  // Entered and left at posedge+1; a following call issues back-to-back.
  task automatic run_op(input lsu_ls_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                        input int gnt_dly, input int rsp_dly, input logic [31:0] rd,
                        input logic err, input bit flush_req, input bit flush_rsp,
                        input logic [31:0] exp_baddr, input logic [3:0] exp_be,
                        input logic exp_we, input logic [31:0] exp_bwd,
                        output int stalls, output int lat, output int req_hi);
    int  phase;
    int  cnt;
    bit  fin;
    stalls = 0; lat = 0; req_hi = 0; phase = 0; cnt = 0; fin = 1'b0;
    i_valid = 1'b1; i_ls_op = op; i_addr = addr; i_wdata = wd;
    @(negedge clk);
    lat = 1;
    if (o_stall) stalls++;
    @(posedge clk); #1;
    i_valid = 1'b0; i_ls_op = LSU_NONE;
    for (int c = 0; c < 400 && !fin; c++) begin
      bus_idle();
      if (phase == 0) begin
        if (cnt == gnt_dly) bus.gnt = 1'b1;
        if (flush_req && cnt == 1) i_flush = 1'b1;
      end else if (cnt == rsp_dly) begin
        bus.rvalid = 1'b1;
        bus.rdata  = rd;
        bus.err    = err;
        if (flush_rsp) i_flush = 1'b1;
      end
      @(negedge clk);
      lat++;
      if (o_stall) stalls++;
      if (phase == 0) begin
        if (bus.req) req_hi++;
        if (cnt == 0) begin
          chk("bus_addr", bus.addr, exp_baddr);
          chk("bus_be", {28'd0, bus.be}, {28'd0, exp_be});
          chk("bus_we", {31'd0, bus.we}, {31'd0, exp_we});
          if (exp_we) chk("bus_wdata", bus.wdata, exp_bwd);
        end
        if (bus.gnt) begin phase = 1; cnt = 0; end
        else cnt++;
      end else begin
        if (!o_stall) fin = 1'b1;
        else cnt++;
      end
      @(posedge clk); #1;
    end
    bus_idle();
    chk("op_completed", {31'd0, fin}, 32'd1);
  endtask

  task automatic run_misal(input lsu_ls_op_t op, input logic [31:0] addr, input logic [3:0] fl);
    sb_q.push_back(mk(32'd0, fl));
    i_valid = 1'b1; i_ls_op = op; i_addr = addr; i_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("misal_stall", {31'd0, o_stall}, 32'd0);
    chk("misal_req", {31'd0, bus.req}, 32'd0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_ls_op = LSU_NONE;
    @(negedge clk);
    chk("misal_req_after", {31'd0, bus.req}, 32'd0);
    @(posedge clk); #1;
  endtask

  int st, lt, rq;

  initial begin
    bus_idle();
    @(negedge clk);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_bus_req", {31'd0, bus.req}, 32'd0);
    chk("rst_bus_addr", bus.addr, 32'd0);
    chk("rst_bus_be", {28'd0, bus.be}, 32'd0);
    chk("rst_bus_wdata", bus.wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LW, immediate gnt and rvalid: accept + REQ stall, done on the third cycle
    sb_q.push_back(mk(32'hDEAD_BEEF, 4'b0000));
    run_op(LSU_LW, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0,
           32'h100, 4'hF, 1'b0, 32'h0, st, lt, rq);
    chk("lw_stall_cycles", st, 2);
    chk("lw_latency", lt, 3);
    chk("lw_req_cycles", rq, 1);

    sb_q.push_back(mk(32'hFFFF_FF80, 4'b0000));
    run_op(LSU_LB, 32'h103, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 1'b0, 1'b0,
           32'h100, 4'b1000, 1'b0, 32'h0, st, lt, rq);
    sb_q.push_back(mk(32'h0000_0080, 4'b0000));
    run_op(LSU_LBU, 32'h103, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 1'b0, 1'b0,
           32'h100, 4'b1000, 1'b0, 32'h0, st, lt, rq);
    sb_q.push_back(mk(32'hFFFF_8011, 4'b0000));
    run_op(LSU_LH, 32'h102, 32'h0, 0, 0, 32'h8011_2233, 1'b0, 1'b0, 1'b0,
           32'h100, 4'b1100, 1'b0, 32'h0, st, lt, rq);

    sb_q.push_back(mk(32'h0000_2233, 4'b0000));
    run_op(LSU_LHU, 32'h100, 32'h0, 2, 3, 32'h8011_2233, 1'b0, 1'b0, 1'b0,
           32'h100, 4'b0011, 1'b0, 32'h0, st, lt, rq);
    chk("lhu_slow_stall", st, 7);
    chk("lhu_slow_latency", lt, 8);

    sb_q.push_back(mk(32'h0, 4'b0000));
    run_op(LSU_SH, 32'h202, 32'h0000_ABCD, 0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0,
           32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD, st, lt, rq);
    sb_q.push_back(mk(32'h0, 4'b0000));
    run_op(LSU_SB, 32'h301, 32'h0000_00EF, 1, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0,
           32'h300, 4'b0010, 1'b1, 32'hEFEF_EFEF, st, lt, rq);

    sb_q.push_back(mk(32'h0, 4'b0001));
    run_op(LSU_SW, 32'h500, 32'hCAFE_F00D, 0, 1, 32'h0, 1'b1, 1'b0, 1'b0,
           32'h500, 4'hF, 1'b1, 32'hCAFE_F00D, st, lt, rq);
    sb_q.push_back(mk(32'h0, 4'b0010));
    run_op(LSU_LW, 32'h504, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0,
           32'h504, 4'hF, 1'b0, 32'h0, st, lt, rq);

    run_misal(LSU_LW, 32'h101, 4'b1000);
    run_misal(LSU_SW, 32'h102, 4'b0100);
    run_misal(LSU_LH, 32'h101, 4'b1000);
    run_misal(LSU_SH, 32'h203, 4'b0100);

    // Flushed in REQ with gnt held off: request must persist, result dropped
    run_op(LSU_LW, 32'h400, 32'h0, 5, 0, 32'h5555_AAAA, 1'b0, 1'b1, 1'b0,
           32'h400, 4'hF, 1'b0, 32'h0, st, lt, rq);
    chk("flush_req_cycles", rq, 6);
    chk("flush_drain_stall", st, 7);
    run_op(LSU_LB, 32'h001, 32'h0, 0, 0, 32'h0000_7F00, 1'b0, 1'b0, 1'b1,
           32'h000, 4'b0010, 1'b0, 32'h0, st, lt, rq);
    sb_q.push_back(mk(32'h0BAD_F00D, 4'b0000));
    run_op(LSU_LW, 32'h008, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0,
           32'h008, 4'hF, 1'b0, 32'h0, st, lt, rq);

    i_valid = 1'b1; i_ls_op = LSU_LW; i_addr = 32'h600; i_flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_ls_op = LSU_NONE; i_flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_req", {31'd0, bus.req}, 32'd0);
    @(posedge clk); #1;

    i_valid = 1'b1; i_ls_op = LSU_LW; i_addr = 32'h800;
    @(posedge clk); #1;
    i_valid = 1'b0; i_ls_op = LSU_NONE;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_req", {31'd0, bus.req}, 32'd0);
    chk("midreset_stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef COTM32_LSU_TIMEOUT_EN
    sb_q.push_back(mk(32'h0, 4'b0010));
    run_op(LSU_LW, 32'h700, 32'h0, 0, -1, 32'h0, 1'b0, 1'b0, 1'b0,
           32'h700, 4'hF, 1'b0, 32'h0, st, lt, rq);
    chk("timeout_latency", lt, 257);
    bus.rvalid = 1'b1; bus.rdata = 32'h1111_1111;
    @(negedge clk);
    chk("late_rvalid_stall", {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    bus_idle();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
